// File: rtl/led_blink_tx.sv
// Blinks `led` N times (ON/OFF phases), holds a low guard gap, then strobes `done` for one cycle.
// Optional macro LED_BLINK_REPEAT_EN adds `repeat_en` to replay the burst instead of finishing.
module led_blink_tx #(
    parameter int CNT_W      = 4,
    parameter int ON_CYCLES  = 2,
    parameter int OFF_CYCLES = 3,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
`ifdef LED_BLINK_REPEAT_EN
    input  logic             repeat_en,
`endif
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam int MAX_PH = (ON_CYCLES > OFF_CYCLES)
                          ? ((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES)
                          : ((OFF_CYCLES > GAP_CYCLES) ? OFF_CYCLES : GAP_CYCLES);
    localparam int TMR_W = $clog2(MAX_PH + 1);

    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [CNT_W-1:0] pulses_reg;
    logic             led_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [1:0]       rst_sync_reg;
`ifdef LED_BLINK_REPEAT_EN
    logic [CNT_W-1:0] cnt_latch_reg;
`endif

    // Reset asserts asynchronously but the FSM only leaves reset two edges after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            timer_reg  <= '0;
            pulses_reg <= '0;
            led_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef LED_BLINK_REPEAT_EN
            cnt_latch_reg <= '0;
`endif
        end else if (!rst_sync_reg[1]) begin
            state_reg  <= S_IDLE;
            timer_reg  <= '0;
            pulses_reg <= '0;
            led_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef LED_BLINK_REPEAT_EN
            cnt_latch_reg <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            pulses_reg <= count;
`ifdef LED_BLINK_REPEAT_EN
                            cnt_latch_reg <= count;
`endif
                            timer_reg  <= '0;
                            state_reg  <= S_ON;
                            led_reg    <= 1'b1;
                            busy_reg   <= 1'b1;
                        end else begin
                            state_reg  <= S_DONE;
                            done_reg   <= 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (timer_reg == ON_LAST) begin
                        timer_reg <= '0;
                        state_reg <= S_OFF;
                        led_reg   <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                S_OFF: begin
                    if (timer_reg == OFF_LAST) begin
                        timer_reg  <= '0;
                        pulses_reg <= pulses_reg - 1'b1;
                        // Last pulse finishing: pulses_reg reaches zero, never below.
                        if (pulses_reg == CNT_W'(1)) begin
                            state_reg <= S_GAP;
                        end else begin
                            state_reg <= S_ON;
                            led_reg   <= 1'b1;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                S_GAP: begin
                    if (timer_reg == GAP_LAST) begin
                        timer_reg <= '0;
`ifdef LED_BLINK_REPEAT_EN
                        if (repeat_en) begin
                            pulses_reg <= cnt_latch_reg;
                            state_reg  <= S_ON;
                            led_reg    <= 1'b1;
                        end else begin
                            state_reg <= S_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
`else
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
`endif
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    timer_reg <= '0;
                    led_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign led  = led_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_led_blink_tx.sv
// Randomised self-checking bench for led_blink_tx against a per-cycle arithmetic model of the blink burst.
module tb_led_blink_tx;

    localparam int CNT_W = 4;
    localparam int ON    = 2;
    localparam int OFF   = 3;
    localparam int GAP   = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic             led;
    logic             busy;
    logic             done;
`ifdef LED_BLINK_REPEAT_EN
    logic             repeat_en = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_blink_tx #(
        .CNT_W     (CNT_W),
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .count    (count),
`ifdef LED_BLINK_REPEAT_EN
        .repeat_en(repeat_en),
`endif
        .led      (led),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {led,busy,done} k cycles after the accepting edge of a burst of n pulses.
    function automatic logic [2:0] model_out(input int n, input int k);
        int len;
        int t;
        logic e_led;
        len = (n == 0) ? 0 : n * (ON + OFF) + GAP;
        t   = k - 1;
        if (k <= len) begin
            e_led = (t < n * (ON + OFF)) && ((t % (ON + OFF)) < ON);
            return {e_led, 1'b1, 1'b0};
        end
        return 3'b001;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    // noise: 0 none, 1 random start/count, 2 start held high with count=2.
    task automatic run_burst(input int n, input int noise);
        int len;
        int pulses;
        int busy_cyc;
        logic prev_led;
        len      = (n == 0) ? 0 : n * (ON + OFF) + GAP;
        pulses   = 0;
        busy_cyc = 0;
        prev_led = 1'b0;
        check_val("idle_pre", {29'd0, led, busy, done}, 32'd0);
        start = 1'b1;
        count = CNT_W'(n);
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            check_val("burst_out", {29'd0, led, busy, done}, {29'd0, model_out(n, k)});
            if (led && !prev_led) pulses++;
            prev_led = led;
            if (busy) busy_cyc++;
            if (k <= len) begin
                case (noise)
                    1: begin
                        start = 1'($urandom);
                        count = CNT_W'($urandom);
                    end
                    2: begin
                        start = 1'b1;
                        count = CNT_W'(2);
                    end
                    default: begin
                        start = 1'b0;
                        count = CNT_W'($urandom);
                    end
                endcase
            end else begin
                start = 1'b0;
            end
        end
        check_val("pulse_count", pulses, n);
        check_val("busy_cycles", busy_cyc, len);
        $display("burst count=%0d noise=%0d pulses=%0d busy_cycles=%0d", n, noise, pulses, busy_cyc);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #20;
        check_val("reset_out", {29'd0, led, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("post_reset", {29'd0, led, busy, done}, 32'd0);

        run_burst(3, 0);
        @(negedge clk);
        run_burst(0, 0);
        repeat (2) @(negedge clk);
        run_burst(15, 2);
        @(negedge clk);
        // Back-to-back: the following bursts start in the first IDLE cycle after done.
        run_burst(2, 1);
        @(negedge clk);
        run_burst(1, 0);

        for (int i = 0; i < 10; i++) begin
            int gap_cyc;
            gap_cyc = $urandom_range(1, 3);
            repeat (gap_cyc) @(negedge clk);
            run_burst($urandom_range(0, 15), $urandom_range(0, 1));
        end

        // Reset asserted in the middle of an ON phase.
        @(negedge clk);
        start = 1'b1;
        count = CNT_W'(3);
        @(negedge clk);
        start = 1'b0;
        check_val("pre_rst_on", {29'd0, led, busy, done}, 32'b110);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst", {29'd0, led, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("rst_quiet", {29'd0, led, busy, done}, 32'd0);
        end
        run_burst(1, 0);
        $display("reset mid-ON then count=1 burst");

`ifdef LED_BLINK_REPEAT_EN
        @(negedge clk);
        repeat_en = 1'b1;
        start = 1'b1;
        count = CNT_W'(2);
        for (int k = 1; k <= 43; k++) begin
            logic [2:0] e;
            int pos;
            @(negedge clk);
            start = 1'b0;
            pos = (k - 1) % 14;
            if (k <= 42) e = {(pos < 10) && ((pos % 5) < 2), 1'b1, 1'b0};
            else         e = 3'b001;
            check_val("repeat_out", {29'd0, led, busy, done}, {29'd0, e});
            if (k == 29) repeat_en = 1'b0;
        end
        $display("repeat burst count=2 three rounds");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
